// File: rtl/qpsk_tx_shaper.sv
// qpsk_tx_shaper
// QPSK symbol mapper followed by a 2x half-band pulse shaper, paced at the ADC sample
// rate by a fractional tick generator. Feeds I/Q stimulus into the timing-recovery chain.
// Build option: define PRBS_GEN_EN to source every symbol from an internal PRBS-9
// instead of the sym_valid/sym_ready handshake.
module qpsk_tx_shaper #(
    parameter logic [31:0] PHASE_INC = 32'd438086664,
    parameter int          AMP       = 8192,
    parameter int          DATA_W    = 16,
    parameter int          COEF_W    = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [1:0]  sym_bits,
    output logic [15:0] I_dac,
    output logic [15:0] Q_dac,
    output logic        out_valid,
    output logic        sym_strobe,
    output logic        underrun
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + 2;
    localparam int SHIFT  = 14;

    // Half-band taps: centre tap for the on-symbol phase, near/far pairs for the midpoint.
    localparam logic signed [COEF_W:0] C_CENTER = (COEF_W + 1)'(16384);
    localparam logic signed [COEF_W:0] C_NEAR   = (COEF_W + 1)'(9216);
    localparam logic signed [COEF_W:0] C_FAR    = (COEF_W + 1)'(1024);

    localparam logic signed [DATA_W-1:0] AMP_POS = DATA_W'(AMP);
    localparam logic signed [DATA_W-1:0] AMP_NEG = -AMP_POS;

    localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN = -SAT_MAX - ACC_W'(1);
    localparam logic signed [DATA_W-1:0] DAC_MAX = DATA_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [DATA_W-1:0] DAC_MIN = -DAC_MAX - DATA_W'(1);

    // Bit 0 maps to the positive level, bit 1 to the negative level.
    function automatic logic signed [DATA_W-1:0] map_level(input logic bit_in);
        return bit_in ? AMP_NEG : AMP_POS;
    endfunction

    // Full-precision signed coefficient x sample product.
    function automatic logic signed [PROD_W-1:0] coef_mul(
        input logic signed [COEF_W:0]   coef,
        input logic signed [DATA_W-1:0] smp
    );
        return PROD_W'(coef) * PROD_W'(smp);
    endfunction

    // Centre pair adds, outer pair subtracts (negative half-band side lobes).
    function automatic logic signed [ACC_W-1:0] tap_sum(
        input logic signed [PROD_W-1:0] p_a,
        input logic signed [PROD_W-1:0] p_b,
        input logic signed [PROD_W-1:0] p_c,
        input logic signed [PROD_W-1:0] p_d
    );
        return ACC_W'(p_a) + ACC_W'(p_b) - ACC_W'(p_c) - ACC_W'(p_d);
    endfunction

    // Remove the Q14 coefficient scaling (truncating toward -inf) and clip to DAC range.
    function automatic logic signed [DATA_W-1:0] shift_sat(input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W-1:0] q;
        q = y >>> SHIFT;
        if (q > SAT_MAX) begin
            return DAC_MAX;
        end else if (q < SAT_MIN) begin
            return DAC_MIN;
        end
        return q[DATA_W-1:0];
    endfunction

    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        tick;
    logic        phase;
    logic        sym_slot;
    logic        sym_take;
    logic [1:0]  new_bits;

    logic signed [DATA_W-1:0] dly [2][4];
    logic                     vld_p0;
    logic                     phase_p0;
    logic signed [PROD_W-1:0] prod_p1 [2][4];
    logic                     vld_p1;
    logic                     strobe_p1;
    logic signed [DATA_W-1:0] dac_p2 [2];

    assign acc_sum  = {1'b0, acc} + {1'b0, PHASE_INC};
    assign tick     = acc_sum[32];
    assign sym_slot = tick & ~phase;

`ifdef PRBS_GEN_EN
    logic [8:0] prbs;
    logic       prbs_b0;
    logic       prbs_b1;

    // Two successive PRBS-9 (x^9 + x^5 + 1) output bits: first feeds I, second feeds Q.
    assign prbs_b0 = prbs[8] ^ prbs[4];
    assign prbs_b1 = prbs[7] ^ prbs[3];

    // Advance the generator by two bits on every symbol slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            prbs <= 9'h1FF;
        end else if (sym_slot) begin
            prbs <= {prbs[6:0], prbs_b0, prbs_b1};
        end
    end

    assign sym_ready = 1'b0;
    assign sym_take  = 1'b1;
    assign new_bits  = {prbs_b0, prbs_b1};
`else
    assign sym_ready = sym_slot & ~reset;
    assign sym_take  = sym_valid;
    assign new_bits  = sym_bits;
`endif

    // Fractional sample-rate accumulator; its carry-out is the sample tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_sum[31:0];
        end
    end

    // Tick stage: phase toggle, delay-line shift on symbol slots, underrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= 1'b0;
            vld_p0   <= 1'b0;
            phase_p0 <= 1'b0;
            underrun <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                for (int k = 0; k < 4; k++) begin
                    dly[ch][k] <= '0;
                end
            end
        end else begin
            vld_p0   <= tick;
            phase_p0 <= phase;
            underrun <= sym_slot & ~sym_take;
            if (tick) begin
                phase <= ~phase;
            end
            if (sym_slot) begin
                for (int ch = 0; ch < 2; ch++) begin
                    dly[ch][3] <= dly[ch][2];
                    dly[ch][2] <= dly[ch][1];
                    dly[ch][1] <= dly[ch][0];
                end
                dly[0][0] <= sym_take ? map_level(new_bits[1]) : '0;
                dly[1][0] <= sym_take ? map_level(new_bits[0]) : '0;
            end
        end
    end

    // ---- p0 -> p1: tap products from the post-shift delay line ----
    // Multiply stage; products only change on a tick so they hold between samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            strobe_p1 <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                for (int k = 0; k < 4; k++) begin
                    prod_p1[ch][k] <= '0;
                end
            end
        end else begin
            vld_p1    <= vld_p0;
            strobe_p1 <= vld_p0 & ~phase_p0;
            if (vld_p0) begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (!phase_p0) begin
                        prod_p1[ch][0] <= coef_mul(C_CENTER, dly[ch][2]);
                        prod_p1[ch][1] <= '0;
                        prod_p1[ch][2] <= '0;
                        prod_p1[ch][3] <= '0;
                    end else begin
                        prod_p1[ch][0] <= coef_mul(C_NEAR, dly[ch][2]);
                        prod_p1[ch][1] <= coef_mul(C_NEAR, dly[ch][1]);
                        prod_p1[ch][2] <= coef_mul(C_FAR, dly[ch][3]);
                        prod_p1[ch][3] <= coef_mul(C_FAR, dly[ch][0]);
                    end
                end
            end
        end
    end

    // ---- p1 -> p2: sum, rescale, saturate ----
    // Output stage; DAC words are held until the next sample pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            dac_p2[0]  <= '0;
            dac_p2[1]  <= '0;
        end else begin
            out_valid  <= vld_p1;
            sym_strobe <= vld_p1 & strobe_p1;
            if (vld_p1) begin
                for (int ch = 0; ch < 2; ch++) begin
                    dac_p2[ch] <= shift_sat(tap_sum(prod_p1[ch][0], prod_p1[ch][1],
                                                    prod_p1[ch][2], prod_p1[ch][3]));
                end
            end
        end
    end

    assign I_dac = dac_p2[0];
    assign Q_dac = dac_p2[1];

endmodule
